// File: rtl/wb_addr_gen.sv
// Write-back destination address generator: captures the destination register at fetch
// and issues a one-cycle register-file write strobe after execute or after load data arrives.
module wb_addr_gen #(
  parameter int          ADDR_W   = 5,
  parameter logic [3:0]  LOAD_OP  = 4'b1001,
  parameter logic [3:0]  NOWB_OP0 = 4'b0101,
  parameter logic [3:0]  NOWB_OP1 = 4'b1111,
  parameter int          TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_fetch,
  input  logic [3:0]        I,
  input  logic [ADDR_W-1:0] RD_addr,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] WR_addr,
  output logic              WR_en,
  output logic              busy,
  output logic              timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_MEM} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              to_nxt;
  logic              msb_zero;

  // Same MSB forcing rule the read side applies at fetch.
  always_comb begin
    msb_zero = 1'b0;
    case (I)
      4'b0011, 4'b0110, 4'b0111, 4'b1000, 4'b1010, 4'b1110: msb_zero = 1'b1;
      default: msb_zero = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = WR_addr;
    cnt_nxt   = cnt;
    to_nxt    = 1'b0;
    case (state)
      IDLE, WRITE: begin
        state_nxt = IDLE;
        if (en_fetch) begin
          addr_nxt = {(msb_zero ? 1'b0 : RD_addr[ADDR_W-1]), RD_addr[ADDR_W-2:0]};
          if (I == LOAD_OP) begin
            state_nxt = WAIT_MEM;
            cnt_nxt   = '0;
          end else if (I == NOWB_OP0 || I == NOWB_OP1) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      WAIT_MEM: begin
        // mem_ready takes priority over an expiring counter
        if (mem_ready) begin
          state_nxt = WRITE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt = IDLE;
          to_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      WR_addr     <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      WR_addr     <= addr_nxt;
      cnt         <= cnt_nxt;
      timeout_err <= to_nxt;
    end
  end

  assign WR_en = (state == WRITE);
  assign busy  = (state == WAIT_MEM);

endmodule

// File: tb/tb_wb_addr_gen.sv
// Scoreboard bench for wb_addr_gen: stimulus pushes expected write/timeout events,
// a negedge monitor pops and compares whenever WR_en or timeout_err is seen.
module tb_wb_addr_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic       en_fetch;
  logic [3:0] I;
  logic [4:0] RD_addr;
  logic       mem_ready;
  logic [4:0] WR_addr;
  logic       WR_en;
  logic       busy;
  logic       timeout_err;

  typedef struct {
    bit         is_to;
    logic [4:0] addr;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  wb_addr_gen dut (
    .clk(clk), .rst(rst), .en_fetch(en_fetch), .I(I), .RD_addr(RD_addr),
    .mem_ready(mem_ready), .WR_addr(WR_addr), .WR_en(WR_en), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] op, input logic [4:0] rd);
    en_fetch = 1'b1;
    I        = op;
    RD_addr  = rd;
    tick();
    en_fetch = 1'b0;
  endtask

  task automatic push(input bit is_to, input logic [4:0] a);
    ev_t e;
    e.is_to = is_to;
    e.addr  = a;
    exp_q.push_back(e);
  endtask

  // Monitor: every observed strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (WR_en || timeout_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: WR_en=%0b timeout_err=%0b WR_addr=%0h, none expected",
                 WR_en, timeout_err, WR_addr);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.is_to) begin
          chk("timeout_pulse", {WR_en, timeout_err}, 2'b01);
        end else begin
          chk("write_strobe", {WR_en, timeout_err}, 2'b10);
          chk("write_addr", WR_addr, e.addr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; en_fetch = 1'b0; I = 4'h0; RD_addr = 5'h0; mem_ready = 1'b0;
    repeat (2) tick();
    chk("reset_wr_en", WR_en, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_timeout", timeout_err, 1'b0);
    chk("reset_wr_addr", WR_addr, 5'h00);
    rst = 1'b0;
    tick();

    // ALU op: strobe the cycle after the fetch edge
    push(0, 5'h13);
    fetch(4'b0001, 5'h13);
    chk("alu_latency_wr_en", WR_en, 1'b1);
    tick();
    chk("alu_single_pulse", WR_en, 1'b0);
    tick();

    // MSB forced to 0, then a no-write-back op (captured but no strobe)
    push(0, 5'h0A);
    fetch(4'b0110, 5'h1A);
    repeat (2) tick();
    fetch(4'b0101, 5'h1F);
    chk("nowb_capture", WR_addr, 5'h1F);
    repeat (3) tick();

    // Load with mem_ready in the third WAIT_MEM cycle; fetch while busy ignored
    push(0, 5'h07);
    fetch(4'b1001, 5'h07);
    chk("load_busy_c1", busy, 1'b1);
    fetch(4'b0001, 5'h02);
    chk("load_busy_c2", busy, 1'b1);
    chk("load_addr_held", WR_addr, 5'h07);
    tick();
    chk("load_busy_c3", busy, 1'b1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("load_write_busy", busy, 1'b0);
    chk("load_write_en", WR_en, 1'b1);
    repeat (2) tick();

    // Load timeout: busy for exactly TIMEOUT cycles, then an error pulse
    push(1, 5'h00);
    fetch(4'b1001, 5'h04);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    chk("timeout_busy_cycles", n, 15);
    repeat (2) tick();

    // mem_ready in the final counted cycle wins over the timeout
    push(0, 5'h08);
    fetch(4'b1001, 5'h08);
    repeat (14) tick();
    chk("boundary_still_busy", busy, 1'b1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("boundary_write", WR_en, 1'b1);
    repeat (2) tick();

    // Back-to-back ALU writes to r1, r2, r3
    push(0, 5'h01); push(0, 5'h02); push(0, 5'h03);
    for (int r = 1; r <= 3; r++) begin
      fetch(4'b0001, 5'(r));
      en_fetch = (r < 3);
      chk("b2b_wr_en", WR_en, 1'b1);
    end
    en_fetch = 1'b0;
    tick();
    chk("b2b_end", WR_en, 1'b0);
    repeat (2) tick();

    // Reset mid-load aborts the operation asynchronously
    fetch(4'b1001, 5'h0C);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_addr", WR_addr, 5'h00);
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    repeat (2) tick();
    mem_ready = 1'b0;
    chk("post_rst_busy", busy, 1'b0);
    repeat (3) tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
